// File: rtl/spi_shift_engine.sv
// spi_shift_engine: single-word SPI master that pops a TX FIFO, shifts 32 bits in any
// CPOL/CPHA mode with a programmable SCLK divider, and pushes the received word to an RX FIFO.
module spi_shift_engine (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [7:0]  ClkDiv,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        TxEmpty,
  output logic        TxRead,
  input  logic [31:0] TxData,
  input  logic        RxFull,
  output logic        RxWrite,
  output logic [31:0] RxData,
  output logic        SCLK,
  output logic        MOSI,
  output logic        CS_n,
  input  logic        MISO,
  output logic        Busy,
  output logic        RxOverrun,
  input  logic        ClearOvr
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, HOLD, STORE, GAP} state_t;
  state_t state, nxt;
  logic [7:0] hp, div_l;
  logic [6:0] edges;
  logic [32:0] tx;
  logic [31:0] rx;
  logic cpol_l, cpha_l, sclk, cs_n, ovr, tc, edge_now, lead;
  assign tc = hp == div_l;
  assign edge_now = state == SHIFT && tc;
  assign lead = ~edges[0];
  assign SCLK = sclk;
  assign CS_n = cs_n;
  assign RxData = rx;
  assign RxOverrun = ovr;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = Enable && !TxEmpty ? FETCH : IDLE;
      FETCH:   nxt = LOAD;
      LOAD:    nxt = SHIFT;
      SHIFT:   nxt = edge_now && edges == 7'd63 ? HOLD : SHIFT;
      HOLD:    nxt = tc ? STORE : HOLD;
      STORE:   nxt = GAP;
      GAP:     nxt = tc ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    TxRead = state == FETCH;
    RxWrite = state == STORE && !RxFull;
    Busy = state != IDLE;
    MOSI = (state == SHIFT || state == HOLD || state == STORE) && tx[32];
  end
  // tx is one bit wider so CPHA=1 can present bit 31 on its first leading-edge shift
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      hp <= '0;
      div_l <= '0;
      edges <= '0;
      tx <= '0;
      rx <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      sclk <= 1'b0;
      cs_n <= 1'b1;
      ovr <= 1'b0;
    end else begin
      hp <= (tc || !(state inside {SHIFT, HOLD, GAP})) ? '0 : hp + 8'd1;
      cs_n <= !(nxt inside {LOAD, SHIFT, HOLD, STORE});
      ovr <= (state == STORE && RxFull) || (ovr && !ClearOvr);
      sclk <= (state == FETCH || state == LOAD) ? CPOL : edge_now ? ~sclk : state == SHIFT ? sclk : cpol_l;
      if (state == LOAD) begin
        div_l <= ClkDiv;
        cpol_l <= CPOL;
        cpha_l <= CPHA;
        edges <= '0;
        tx <= CPHA ? {1'b0, TxData} : {TxData, 1'b0};
      end else if (edge_now) begin
        edges <= edges + 7'd1;
        if (lead != cpha_l) rx <= {rx[30:0], MISO};
        else tx <= {tx[31:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed checks of spi_shift_engine with a TX FIFO model and an
// SCLK/CS_n monitor; expected words and cycle counts are worked out by hand.
module tb_spi_shift_engine;
  logic Clock = 1'b0;
  logic Reset, Enable, CPOL, CPHA, TxEmpty, TxRead, RxFull, RxWrite;
  logic SCLK, MOSI, CS_n, MISO, Busy, RxOverrun, ClearOvr, loop, miso_val;
  logic [7:0] ClkDiv;
  logic [31:0] TxData = '0;
  logic [31:0] RxData;
  logic [31:0] tx_mem [16];
  logic [31:0] rx_log [32];
  logic [31:0] mosi_word = '0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, first = 1'b1;
  int tx_wr, tx_rd, rx_n, txr_n, sclk_edges, cs_low, gap_bad, viol;
  int since, hi_run, gap_run, last_hi, last_gap, exp_gap;
  int n_cmp, n_bad, s_edges, s_txr, s_rx, s_cs, s_gap;

  spi_shift_engine dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .ClkDiv(ClkDiv), .CPOL(CPOL), .CPHA(CPHA),
    .TxEmpty(TxEmpty), .TxRead(TxRead), .TxData(TxData), .RxFull(RxFull), .RxWrite(RxWrite),
    .RxData(RxData), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n), .MISO(MISO), .Busy(Busy),
    .RxOverrun(RxOverrun), .ClearOvr(ClearOvr)
  );

  always #5 Clock = ~Clock;
  assign TxEmpty = tx_wr == tx_rd;
  assign MISO = loop ? MOSI : miso_val;

  // FIFO model and bus monitor; SCLK rising is the MOSI sample edge in modes 0 and 3
  always @(negedge Clock) begin
    if (TxRead && TxEmpty) viol++;
    if (RxWrite && RxFull) viol++;
    if (CS_n && MOSI) viol++;
    if (TxRead) begin
      TxData = tx_mem[tx_rd];
      tx_rd++;
      txr_n++;
    end
    if (RxWrite) begin
      rx_log[rx_n] = RxData;
      rx_n++;
    end
    if (!CS_n) cs_low++;
    since++;
    if (!CS_n && !prev_cs && SCLK != prev_sclk) begin
      sclk_edges++;
      if (!first && since != exp_gap) gap_bad++;
      first = 1'b0;
      since = 0;
      if (SCLK) mosi_word = {mosi_word[30:0], MOSI};
    end
    if (CS_n) begin
      first = 1'b1;
      hi_run++;
      if (Busy && !TxRead) gap_run++;
    end else if (prev_cs) begin
      last_hi = hi_run;
      last_gap = gap_run;
      hi_run = 0;
      gap_run = 0;
    end
    prev_cs = CS_n;
    prev_sclk = SCLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    tx_mem[tx_wr] = w;
    tx_wr++;
  endtask

  task automatic snap();
    s_edges = sclk_edges;
    s_txr = txr_n;
    s_rx = rx_n;
    s_cs = cs_low;
    s_gap = gap_bad;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((Busy || !(TxEmpty || !Enable)) && k < 3000);
    check(tag, Busy, 0);
  endtask

  task automatic wait_cs(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (CS_n && k < 100);
    check(tag, CS_n, 0);
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; ClkDiv = 8'd0; CPOL = 1'b0; CPHA = 1'b0;
    RxFull = 1'b0; ClearOvr = 1'b0; loop = 1'b1; miso_val = 1'b0; exp_gap = 1;
    tick();
    check("rst_outs", {CS_n, SCLK, MOSI, TxRead, RxWrite, Busy, RxOverrun}, 7'b1000000);
    check("rst_rxdata", RxData, 32'h0);
    tick();
    Reset = 1'b0;
    push(32'hA5A5_0F0F);
    repeat (5) tick();
    check("idle_no_enable", {Busy, TxRead}, 2'b00);
    // mode 0, divider 0, loopback
    snap();
    Enable = 1'b1;
    wait_done("m0_done");
    check("m0_edges", sclk_edges - s_edges, 64);
    check("m0_txread", txr_n - s_txr, 1);
    check("m0_rxwrite", rx_n - s_rx, 1);
    check("m0_rxdata", rx_log[s_rx], 32'hA5A5_0F0F);
    check("m0_cs_low", cs_low - s_cs, 67);
    check("m0_mosi", mosi_word, 32'hA5A5_0F0F);
    check("m0_halfper", gap_bad - s_gap, 0);
    // mode 3, divider 3, MISO tied high
    CPOL = 1'b1; CPHA = 1'b1; ClkDiv = 8'd3; loop = 1'b0; miso_val = 1'b1; exp_gap = 4;
    snap();
    push(32'h8000_0001);
    wait_done("m3_done");
    check("m3_edges", sclk_edges - s_edges, 64);
    check("m3_halfper", gap_bad - s_gap, 0);
    check("m3_mosi", mosi_word, 32'h8000_0001);
    check("m3_rxdata", rx_log[s_rx], 32'hFFFF_FFFF);
    check("m3_cs_low", cs_low - s_cs, 262);
    check("m3_sclk_idle", SCLK, 1);
    // two queued words, divider 1
    CPOL = 1'b0; CPHA = 1'b0; ClkDiv = 8'd1; loop = 1'b1; exp_gap = 2;
    snap();
    push(32'h1234_5678);
    push(32'hCAFE_F00D);
    wait_done("b2b_done");
    check("b2b_txread", txr_n - s_txr, 2);
    check("b2b_rxwrite", rx_n - s_rx, 2);
    check("b2b_word0", rx_log[s_rx], 32'h1234_5678);
    check("b2b_word1", rx_log[s_rx + 1], 32'hCAFE_F00D);
    check("b2b_gap", last_gap, 2);
    check("b2b_cs_high", last_hi, 4);
    check("b2b_edges", sclk_edges - s_edges, 128);
    // Enable dropped mid-word
    ClkDiv = 8'd0; exp_gap = 1;
    snap();
    push(32'h600D_F00D);
    push(32'h0000_0001);
    wait_cs("en_start");
    repeat (10) tick();
    Enable = 1'b0;
    wait_done("en_drop_done");
    check("en_drop_txread", txr_n - s_txr, 1);
    check("en_drop_rxwrite", rx_n - s_rx, 1);
    check("en_drop_rxdata", rx_log[s_rx], 32'h600D_F00D);
    check("en_drop_pending", TxEmpty, 0);
    snap();
    Enable = 1'b1;
    wait_done("en_resume_done");
    check("en_resume_rxdata", rx_log[s_rx], 32'h0000_0001);
    // overrun, clear, then set and clear together in STORE
    RxFull = 1'b1;
    snap();
    push(32'h0000_FFFF);
    wait_done("ovr_done");
    check("ovr_rx_lost", rx_n - s_rx, 0);
    check("ovr_set", RxOverrun, 1);
    ClearOvr = 1'b1;
    tick();
    ClearOvr = 1'b0;
    check("ovr_clear", RxOverrun, 0);
    push(32'hFFFF_0000);
    wait_cs("ovr2_start");
    repeat (66) tick();
    check("store_align", {CS_n, Busy}, 2'b01);
    ClearOvr = 1'b1;
    tick();
    ClearOvr = 1'b0;
    check("ovr_set_wins", RxOverrun, 1);
    check("gap_cs", CS_n, 1);
    wait_done("ovr2_done");
    check("ovr2_rx_lost", rx_n - s_rx, 0);
    RxFull = 1'b0;
    // reset after 10 edges in mode 2
    CPOL = 1'b1; ClkDiv = 8'd2; exp_gap = 3;
    snap();
    push(32'hDEAD_BEEF);
    begin
      int k = 0;
      do begin
        tick();
        k++;
      end while (sclk_edges - s_edges < 10 && k < 1000);
    end
    check("ten_edges", sclk_edges - s_edges, 10);
    Reset = 1'b1;
    #1;
    check("rst_mid", {CS_n, SCLK, Busy, MOSI}, 4'b1000);
    repeat (2) tick();
    check("rst_no_write", rx_n - s_rx, 0);
    Reset = 1'b0;
    CPOL = 1'b0; ClkDiv = 8'd0; exp_gap = 1;
    snap();
    push(32'h3C3C_C3C3);
    wait_done("post_rst_done");
    check("post_rst_rxdata", rx_log[s_rx], 32'h3C3C_C3C3);
    check("post_rst_edges", sclk_edges - s_edges, 64);
    // mode inputs changed mid-word take effect only on the next word
    ClkDiv = 8'd1; exp_gap = 2;
    snap();
    push(32'h0F0F_1234);
    wait_cs("mc_start");
    repeat (20) tick();
    CPOL = 1'b1; CPHA = 1'b1; ClkDiv = 8'd0;
    wait_done("mc_done");
    check("mc_edges", sclk_edges - s_edges, 64);
    check("mc_halfper", gap_bad - s_gap, 0);
    check("mc_rxdata", rx_log[s_rx], 32'h0F0F_1234);
    check("mc_mosi", mosi_word, 32'h0F0F_1234);
    check("mc_sclk_idle", SCLK, 0);
    exp_gap = 1;
    snap();
    push(32'h5555_AAAA);
    wait_done("mc_next_done");
    check("mc_next_rxdata", rx_log[s_rx], 32'h5555_AAAA);
    check("mc_next_halfper", gap_bad - s_gap, 0);
    check("mc_next_cs_low", cs_low - s_cs, 67);
    check("mc_next_sclk_idle", SCLK, 1);
    check("protocol_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
